// File: rtl/potato2_pkg.sv
`default_nettype none
// ============================================================================
// Module      : potato2_pkg
// Description : Shared definitions for the Potato-2 control unit: decoded
//               micro-instruction bit positions, PC direction codes and the
//               loop controller state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package potato2_pkg;

   // Bit positions of the decoded micro-instruction vector
   localparam int CTRL_INC   = 0;
   localparam int CTRL_DEC   = 1;
   localparam int CTRL_LEFT  = 2;
   localparam int CTRL_RIGHT = 3;
   localparam int CTRL_OUT   = 4;
   localparam int CTRL_IN    = 5;
   localparam int CTRL_LOOP  = 6;
   localparam int CTRL_DONE  = 7;
   localparam int CTRL_WIDTH = 8;

   // Program counter direction
   localparam logic X_PC_INC = 1'b0;
   localparam logic X_PC_DEC = 1'b1;

   // Loop controller states
   typedef logic [1:0] loop_state_t;
   localparam logic [1:0] ST_RUN       = 2'd0;
   localparam logic [1:0] ST_SKIP_FWD  = 2'd1;
   localparam logic [1:0] ST_SCAN_BACK = 2'd2;
   localparam logic [1:0] ST_ERROR     = 2'd3;

endpackage : potato2_pkg
`default_nettype wire

// File: rtl/potato2_nest_counter.sv
`default_nettype none
// ============================================================================
// Module      : potato2_nest_counter
// Description : Saturating up/down counter with clear and load-1, plus
//               zero / one / max flags. Used for loop depth and scan nesting.
// Revision    : 1.0 - initial release
// ============================================================================
module potato2_nest_counter #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             load_one,
   input  logic             inc,
   input  logic             dec,
   output logic [WIDTH-1:0] count,
   output logic             is_zero,
   output logic             is_one,
   output logic             is_max
);

   localparam logic [WIDTH-1:0] C_ZERO = '0;
   localparam logic [WIDTH-1:0] C_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

   // Count update; clear beats load beats inc beats dec, and the count
   // never wraps in either direction.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= C_ZERO;
      end else if (clr) begin
         count <= C_ZERO;
      end else if (load_one) begin
         count <= C_ONE;
      end else if (inc && !is_max) begin
         count <= count + C_ONE;
      end else if (dec && !is_zero) begin
         count <= count - C_ONE;
      end
   end

   // Flags decoded straight from the stored count
   always_comb begin
      is_zero = (count == C_ZERO);
      is_one  = (count == C_ONE);
      is_max  = &count;
   end

endmodule : potato2_nest_counter
`default_nettype wire

// File: rtl/potato2_loop_control.sv
`default_nettype none
// ============================================================================
// Module      : potato2_loop_control
// Description : Loop-nesting controller. Tracks open loops in forward
//               execution, skips zero-entry loop bodies, scans backwards to
//               the matching LOOP, and halts sticky on nesting errors.
// Revision    : 1.0 - initial release
// ============================================================================
module potato2_loop_control
   import potato2_pkg::*;
#(
   parameter int DEPTH_WIDTH = 8
) (
   input  logic                   Clock,
   input  logic                   Reset_n,
   input  logic                   Valid,
   input  logic                   Loop,
   input  logic                   Done,
   input  logic                   ZeroFlag,
   input  logic                   Clear,
   output logic                   Reverse,
   output logic                   SkipCmd,
   output logic                   Halt,
   output logic                   Overflow,
   output logic                   Underflow,
   output logic [DEPTH_WIDTH-1:0] Depth
);

   loop_state_t            state;
   loop_state_t            state_nxt;
   logic                   accept;
   logic                   ovf_set;
   logic                   unf_set;
   logic                   err_clr;
   logic                   d_inc, d_dec, d_clr;
   logic                   n_inc, n_dec, n_clr, n_load;
   logic                   d_zero, d_one, d_max;
   logic                   n_zero, n_one, n_max;
   logic [DEPTH_WIDTH-1:0] nest;

   potato2_nest_counter #(.WIDTH(DEPTH_WIDTH)) u_depth (
      .clk      (Clock),
      .rst_n    (Reset_n),
      .clr      (d_clr),
      .load_one (1'b0),
      .inc      (d_inc),
      .dec      (d_dec),
      .count    (Depth),
      .is_zero  (d_zero),
      .is_one   (d_one),
      .is_max   (d_max)
   );

   potato2_nest_counter #(.WIDTH(DEPTH_WIDTH)) u_nest (
      .clk      (Clock),
      .rst_n    (Reset_n),
      .clr      (n_clr),
      .load_one (n_load),
      .inc      (n_inc),
      .dec      (n_dec),
      .count    (nest),
      .is_zero  (n_zero),
      .is_one   (n_one),
      .is_max   (n_max)
   );

   // Next-state and counter control; Loop together with Done is not an event
   always_comb begin
      accept    = Valid & (Loop ^ Done);
      state_nxt = state;
      ovf_set   = 1'b0;
      unf_set   = 1'b0;
      err_clr   = 1'b0;
      d_inc     = 1'b0;
      d_dec     = 1'b0;
      d_clr     = 1'b0;
      n_inc     = 1'b0;
      n_dec     = 1'b0;
      n_clr     = 1'b0;
      n_load    = 1'b0;
      case (state)
         ST_RUN: begin
            if (accept && Loop) begin
               if (ZeroFlag) begin
                  state_nxt = ST_SKIP_FWD;
                  n_load    = 1'b1;
               end else if (d_max) begin
                  state_nxt = ST_ERROR;
                  ovf_set   = 1'b1;
               end else begin
                  d_inc = 1'b1;
               end
            end else if (accept && Done) begin
               if (d_zero) begin
                  state_nxt = ST_ERROR;
                  unf_set   = 1'b1;
               end else if (ZeroFlag) begin
                  d_dec = 1'b1;
               end else begin
                  state_nxt = ST_SCAN_BACK;
                  n_load    = 1'b1;
               end
            end
         end
         ST_SKIP_FWD: begin
            if (accept && Loop) begin
               if (n_max) begin
                  state_nxt = ST_ERROR;
                  ovf_set   = 1'b1;
               end else begin
                  n_inc = 1'b1;
               end
            end else if (accept && Done) begin
               n_dec = 1'b1;
               if (n_one) state_nxt = ST_RUN;
            end
         end
         ST_SCAN_BACK: begin
            // Stream is reversed here: DONE opens, LOOP closes
            if (accept && Done) begin
               if (n_max) begin
                  state_nxt = ST_ERROR;
                  ovf_set   = 1'b1;
               end else begin
                  n_inc = 1'b1;
               end
            end else if (accept && Loop) begin
               n_dec = 1'b1;
               if (n_one) state_nxt = ST_RUN;
            end
         end
         default: begin
            if (Clear) begin
               state_nxt = ST_RUN;
               d_clr     = 1'b1;
               n_clr     = 1'b1;
               err_clr   = 1'b1;
            end
         end
      endcase
   end

   // State and registered control outputs
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         state   <= ST_RUN;
         Reverse <= X_PC_INC;
         SkipCmd <= 1'b0;
         Halt    <= 1'b0;
      end else begin
         state   <= state_nxt;
         Reverse <= (state_nxt == ST_SCAN_BACK) ? X_PC_DEC : X_PC_INC;
         SkipCmd <= (state_nxt != ST_RUN);
         Halt    <= (state_nxt == ST_ERROR);
      end
   end

   // Sticky error flags, released only by Clear while halted
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         Overflow  <= 1'b0;
         Underflow <= 1'b0;
      end else if (err_clr) begin
         Overflow  <= 1'b0;
         Underflow <= 1'b0;
      end else begin
         if (ovf_set) Overflow  <= 1'b1;
         if (unf_set) Underflow <= 1'b1;
      end
   end

endmodule : potato2_loop_control
`default_nettype wire

// File: tb/tb_potato2_loop_control.sv
`default_nettype none
// ============================================================================
// Module      : tb_potato2_loop_control
// Description : Directed self-checking bench for potato2_loop_control, with
//               an 8-bit and a 2-bit depth instance driven in parallel.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_potato2_loop_control;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       valid = 1'b0, loop = 1'b0, done = 1'b0, zf = 1'b0, clr = 1'b0;
   logic       rev8, skip8, halt8, ovf8, unf8;
   logic [7:0] depth8;
   logic       rev2, skip2, halt2, ovf2, unf2;
   logic [1:0] depth2;
   int         checks = 0;
   int         failures = 0;

   always #5 clk = ~clk;

   potato2_loop_control #(.DEPTH_WIDTH(8)) dut8 (
      .Clock(clk), .Reset_n(rst_n), .Valid(valid), .Loop(loop), .Done(done),
      .ZeroFlag(zf), .Clear(clr), .Reverse(rev8), .SkipCmd(skip8),
      .Halt(halt8), .Overflow(ovf8), .Underflow(unf8), .Depth(depth8)
   );

   potato2_loop_control #(.DEPTH_WIDTH(2)) dut2 (
      .Clock(clk), .Reset_n(rst_n), .Valid(valid), .Loop(loop), .Done(done),
      .ZeroFlag(zf), .Clear(clr), .Reverse(rev2), .SkipCmd(skip2),
      .Halt(halt2), .Overflow(ovf2), .Underflow(unf2), .Depth(depth2)
   );

   // Observed vectors: {Reverse,SkipCmd,Halt,Overflow,Underflow,Depth}
   wire [12:0] o8 = {rev8, skip8, halt8, ovf8, unf8, depth8};
   wire [6:0]  o2 = {rev2, skip2, halt2, ovf2, unf2, depth2};

   // Present one instruction, then sample just after the capturing edge
   task automatic step(input logic v, input logic l, input logic d,
                       input logic z, input logic c);
      @(negedge clk);
      valid = v; loop = l; done = d; zf = z; clr = c;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      valid = 1'b0; loop = 1'b0; done = 1'b0; zf = 1'b0; clr = 1'b0;
      rst_n = 1'b0;
      #12;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (o8 !== 13'h0000) begin
         $display("FAIL reset8 got=%h exp=%h", o8, 13'h0000); failures++;
      end
      checks++;
      if (o2 !== 7'h00) begin
         $display("FAIL reset2 got=%h exp=%h", o2, 7'h00); failures++;
      end
   endtask

   task automatic test_forward();
      do_reset();
      step(1, 1, 0, 0, 0);
      checks++;
      if (o8 !== 13'h0001) begin
         $display("FAIL fwd_loop got=%h exp=%h", o8, 13'h0001); failures++;
      end
      step(1, 0, 1, 1, 0);
      checks++;
      if (o8 !== 13'h0000) begin
         $display("FAIL fwd_done got=%h exp=%h", o8, 13'h0000); failures++;
      end
   endtask

   task automatic test_skip_fwd();
      logic [12:0] exp [5] = '{13'h0800, 13'h0800, 13'h0800, 13'h0000, 13'h0000};
      do_reset();
      step(1, 1, 0, 1, 0);  // Loop at zero cell
      checks++;
      if (o8 !== exp[0]) begin
         $display("FAIL skip_0 got=%h exp=%h", o8, exp[0]); failures++;
      end
      step(1, 1, 0, 0, 0);  // nested Loop, ZeroFlag ignored
      checks++;
      if (o8 !== exp[1]) begin
         $display("FAIL skip_1 got=%h exp=%h", o8, exp[1]); failures++;
      end
      step(1, 0, 1, 0, 0);
      checks++;
      if (o8 !== exp[2]) begin
         $display("FAIL skip_2 got=%h exp=%h", o8, exp[2]); failures++;
      end
      step(1, 0, 1, 0, 0);  // matching Done
      checks++;
      if (o8 !== exp[3]) begin
         $display("FAIL skip_3 got=%h exp=%h", o8, exp[3]); failures++;
      end
      step(1, 0, 0, 0, 0);  // ordinary instruction
      checks++;
      if (o8 !== exp[4]) begin
         $display("FAIL skip_4 got=%h exp=%h", o8, exp[4]); failures++;
      end
   endtask

   task automatic test_scan_back();
      do_reset();
      step(1, 1, 0, 0, 0);
      step(1, 1, 0, 0, 0);
      checks++;
      if (o8 !== 13'h0002) begin
         $display("FAIL scan_depth got=%h exp=%h", o8, 13'h0002); failures++;
      end
      step(1, 0, 1, 0, 0);  // Done at non-zero cell
      checks++;
      if (o8 !== 13'h1802) begin
         $display("FAIL scan_enter got=%h exp=%h", o8, 13'h1802); failures++;
      end
      step(1, 0, 1, 0, 0);  // reversed: inner Done
      step(1, 1, 0, 0, 0);  // reversed: inner Loop
      checks++;
      if (o8 !== 13'h1802) begin
         $display("FAIL scan_inner got=%h exp=%h", o8, 13'h1802); failures++;
      end
      step(1, 1, 0, 0, 0);  // matching Loop
      checks++;
      if (o8 !== 13'h0002) begin
         $display("FAIL scan_exit got=%h exp=%h", o8, 13'h0002); failures++;
      end
   endtask

   task automatic test_overflow();
      do_reset();
      for (int i = 1; i <= 3; i++) step(1, 1, 0, 0, 0);
      checks++;
      if (o2 !== 7'h03) begin
         $display("FAIL ovf_full got=%h exp=%h", o2, 7'h03); failures++;
      end
      step(1, 1, 0, 0, 0);
      checks++;
      if (o2 !== 7'b0111011) begin
         $display("FAIL ovf_err got=%h exp=%h", o2, 7'b0111011); failures++;
      end
      checks++;
      if (o8 !== 13'h0004) begin
         $display("FAIL ovf_wide got=%h exp=%h", o8, 13'h0004); failures++;
      end
      step(0, 0, 0, 0, 1);  // Clear while halted (2-bit), in RUN (8-bit)
      checks++;
      if (o2 !== 7'h00) begin
         $display("FAIL ovf_clear got=%h exp=%h", o2, 7'h00); failures++;
      end
      checks++;
      if (o8 !== 13'h0004) begin
         $display("FAIL clear_ignored got=%h exp=%h", o8, 13'h0004); failures++;
      end
   endtask

   task automatic test_underflow_idle();
      do_reset();
      step(1, 0, 1, 0, 0);
      checks++;
      if (o8 !== 13'h0D00) begin
         $display("FAIL unf_err got=%h exp=%h", o8, 13'h0D00); failures++;
      end
      step(1, 1, 0, 0, 0);  // still halted
      checks++;
      if (o8 !== 13'h0D00) begin
         $display("FAIL unf_sticky got=%h exp=%h", o8, 13'h0D00); failures++;
      end
      step(0, 0, 0, 0, 1);
      checks++;
      if (o8 !== 13'h0000) begin
         $display("FAIL unf_clear got=%h exp=%h", o8, 13'h0000); failures++;
      end
      step(1, 1, 0, 0, 0);
      for (int i = 0; i < 5; i++) begin
         if (i[0]) step(1, 1, 1, 0, 0);
         else      step(0, 1, 0, 0, 0);
      end
      checks++;
      if (o8 !== 13'h0001) begin
         $display("FAIL idle_hold got=%h exp=%h", o8, 13'h0001); failures++;
      end
   endtask

   task automatic test_reset_mid_scan();
      do_reset();
      step(1, 1, 0, 0, 0);
      step(1, 0, 1, 0, 0);
      checks++;
      if (o8 !== 13'h1801) begin
         $display("FAIL mid_scan got=%h exp=%h", o8, 13'h1801); failures++;
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({rev8, skip8, halt8, depth8} !== 11'h000) begin
         $display("FAIL async_reset got=%h exp=%h", {rev8, skip8, halt8, depth8}, 11'h000);
         failures++;
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_forward();
      test_skip_fwd();
      test_scan_back();
      test_overflow();
      test_underflow_idle();
      test_reset_mid_scan();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_potato2_loop_control
`default_nettype wire
